// File: rtl/stopwatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl_if
//   Bundles the scan-code input strobe and the stopwatch control outputs.
//   master : the side that sends scan codes and observes the controls (PS/2
//            receiver / test harness).
//   slave  : the stopwatch sequencer.
//   Signals
//     key_valid  one-cycle strobe, key_code holds a received byte
//     key_code   [7:0] PS/2 scan-code byte
//     tick_inc   one-cycle increment pulse to the LSB digit counter
//     cnt_clear  one-cycle clear pulse to all digit counters
//     lap_hold   display latches frozen (lap view)
//     running    counting (RUN or LAP)
//     state      [1:0] FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP
// ---------------------------------------------------------------------------
interface stopwatch_ctrl_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic       tick_inc;
  logic       cnt_clear;
  logic       lap_hold;
  logic       running;
  logic [1:0] state;

  modport master (
    output key_valid, key_code,
    input  tick_inc, cnt_clear, lap_hold, running, state
  );

  modport slave (
    input  key_valid, key_code,
    output tick_inc, cnt_clear, lap_hold, running, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//   Stopwatch sequencer between the PS/2 scan-code receiver and the BCD
//   counter chain. Decodes make/break scan codes into start/stop, clear and
//   lap commands, runs the IDLE/RUN/PAUSE/LAP FSM, produces the 1/TICK_HZ
//   increment pulse for the LSB digit and the clear pulse for all digits.
//
//   Ports
//     clk   system clock
//     rst   synchronous, active-high reset
//     bus   stopwatch_ctrl_if.slave (key_valid/key_code in; tick_inc,
//           cnt_clear, lap_hold, running, state out)
//
//   Parameters
//     CLK_HZ, TICK_HZ  prescaler divide DIV = CLK_HZ/TICK_HZ (integer, >= 2)
//     KEY_SS, KEY_CLR, KEY_LAP  make codes of the three command keys
//
//   Build option
//     SWC_REPEAT_FILTER_EN  when defined, a make code equal to the last
//                           accepted make code (no break of that key in
//                           between) is dropped, suppressing typematic
//                           auto-repeat.
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100,
  parameter logic [7:0]  KEY_SS  = 8'h1B,
  parameter logic [7:0]  KEY_CLR = 8'h2D,
  parameter logic [7:0]  KEY_LAP = 8'h4B
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          brk_q, brk_d;
  logic          tick_q, tick_d;
  logic          clr_q, clr_d;

  // ---------------- scan decode ----------------
  logic is_brk, is_ext, is_rel, is_make, make_ok;
  logic cmd_ss, cmd_clr, cmd_lap;

  assign is_brk  = bus.key_valid && (bus.key_code == CODE_BRK);
  assign is_ext  = bus.key_valid && (bus.key_code == CODE_EXT);
  // Byte after F0 is the released key: swallowed, never a command.
  assign is_rel  = bus.key_valid && !is_brk && !is_ext && brk_q;
  assign is_make = bus.key_valid && !is_brk && !is_ext && !brk_q;

`ifdef SWC_REPEAT_FILTER_EN
  logic [7:0] last_q, last_d;

  // Typematic repeat resends the make code with no break in between.
  assign make_ok = is_make && (bus.key_code != last_q);

  always_comb begin
    last_d = last_q;
    if (is_rel && (bus.key_code == last_q))
      last_d = 8'h00;
    else if (cmd_ss || cmd_clr || cmd_lap)
      last_d = bus.key_code;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 8'h00;
    else     last_q <= last_d;
  end
`else
  assign make_ok = is_make;
`endif

  assign cmd_ss  = make_ok && (bus.key_code == KEY_SS);
  assign cmd_clr = make_ok && (bus.key_code == KEY_CLR);
  assign cmd_lap = make_ok && (bus.key_code == KEY_LAP);

  always_comb begin
    brk_d = brk_q;
    if (is_brk)      brk_d = 1'b1;
    else if (is_rel) brk_d = 1'b0;
  end

  // ---------------- FSM ----------------
  logic running_w;
  assign running_w = (state_q == S_RUN) || (state_q == S_LAP);

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_ss)       state_d = S_RUN;
        else if (cmd_clr) clr_d   = 1'b1;
      end
      S_RUN: begin
        if (cmd_ss)       state_d = S_PAUSE;
        else if (cmd_lap) state_d = S_LAP;
      end
      S_PAUSE: begin
        if (cmd_ss) state_d = S_RUN;
        else if (cmd_clr) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end
      end
      S_LAP: begin
        if (cmd_lap)     state_d = S_RUN;
        else if (cmd_ss) state_d = S_PAUSE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- prescaler / tick ----------------
  // Counting and the tick decision use the pre-transition state, so a stop
  // key landing on the wrap cycle still gets its final tick. Entering IDLE
  // (only reachable via clear) zeroes the partial period.
  always_comb begin
    presc_d = presc_q;
    if (state_d == S_IDLE)
      presc_d = '0;
    else if (running_w)
      presc_d = (presc_q == PMAX) ? '0 : presc_q + 1'b1;
  end

  assign tick_d = running_w && (presc_q == PMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      brk_q   <= 1'b0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      brk_q   <= brk_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
    end
  end

  // ---------------- outputs ----------------
  assign bus.tick_inc  = tick_q;
  assign bus.cnt_clear = clr_q;
  assign bus.lap_hold  = (state_q == S_LAP);
  assign bus.running   = running_w;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Directed bench for stopwatch_ctrl at CLK_HZ=1000, TICK_HZ=100 (DIV=10).
//   Keys are strobed for one cycle from a negedge; outputs are sampled on
//   negedges. After send_key returns, the bench sits in the cycle right
//   after the strobe cycle.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  stopwatch_ctrl_if bus();

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_key(input logic [7:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
  endtask

  // Sample n cycles starting with the current one; index 0 = now.
  task automatic scan(input int n, output int ticks, output int first,
                      output int badgap, output int clears);
    int prev;
    ticks = 0; first = -1; badgap = 0; clears = 0; prev = -1;
    for (int i = 0; i < n; i++) begin
      if (bus.tick_inc) begin
        ticks++;
        if (first < 0) first = i;
        if (prev >= 0 && (i - prev) != 10) badgap++;
        prev = i;
      end
      if (bus.cnt_clear) clears++;
      @(negedge clk);
    end
  endtask

  int t, f, g, c;

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;

    // ---- reset state, idle with no keys ----
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", bus.state, 0);
    chk("rst_tick", bus.tick_inc, 0);
    chk("rst_clear", bus.cnt_clear, 0);
    chk("rst_lap", bus.lap_hold, 0);
    chk("rst_run", bus.running, 0);
    rst = 1'b0;
    scan(50, t, f, g, c);
    chk("idle_ticks", t, 0);
    chk("idle_clears", c, 0);
    chk("idle_state", bus.state, 0);
    chk("idle_running", bus.running, 0);

    // ---- start, ten ticks ten cycles apart ----
    do_reset();
    send_key(8'h1B);
    chk("start_state", bus.state, 1);
    chk("start_running", bus.running, 1);
    scan(101, t, f, g, c);
    chk("run_ticks", t, 10);
    chk("run_first", f, 10);
    chk("run_gaps", g, 0);

    // ---- pause after 4 running cycles, resume finishes partial period ----
    do_reset();
    send_key(8'h1B);
    scan(3, t, f, g, c);
    chk("pre_pause_ticks", t, 0);
    send_key(8'h1B);
    chk("pause_state", bus.state, 2);
    chk("pause_running", bus.running, 0);
    scan(20, t, f, g, c);
    chk("pause_ticks", t, 0);
    send_key(8'h1B);
    chk("resume_state", bus.state, 1);
    scan(10, t, f, g, c);
    chk("resume_first", f, 6);
    chk("resume_ticks", t, 1);

    // ---- clear from PAUSE, prescaler reset ----
    do_reset();
    send_key(8'h1B);
    send_key(8'h1B);
    chk("p2_state", bus.state, 2);
    send_key(8'h2D);
    chk("clr_pulse", bus.cnt_clear, 1);
    chk("clr_state", bus.state, 0);
    @(negedge clk);
    chk("clr_width", bus.cnt_clear, 0);
    scan(30, t, f, g, c);
    chk("clr_no_ticks", t, 0);
    chk("clr_no_clears", c, 0);
    send_key(8'h1B);
    scan(12, t, f, g, c);
    chk("after_clr_first", f, 10);
    send_key(8'h1B);
    send_key(8'h2D);
    // clear from IDLE
    send_key(8'h2D);
    chk("idle_clr_pulse", bus.cnt_clear, 1);
    chk("idle_clr_state", bus.state, 0);

    // ---- lap ----
    do_reset();
    send_key(8'h1B);
    send_key(8'h4B);
    chk("lap_state", bus.state, 3);
    chk("lap_hold", bus.lap_hold, 1);
    chk("lap_running", bus.running, 1);
    scan(12, t, f, g, c);
    chk("lap_tick_first", f, 9);
    chk("lap_ticks", t, 1);
    send_key(8'h2D);
    chk("lap_clr_ignored", bus.state, 3);
    chk("lap_clr_nopulse", bus.cnt_clear, 0);
    send_key(8'h4B);
    chk("unlap_state", bus.state, 1);
    chk("unlap_hold", bus.lap_hold, 0);
    send_key(8'h2D);
    chk("run_clr_ignored", bus.state, 1);
    chk("run_clr_nopulse", bus.cnt_clear, 0);
    send_key(8'h4B);
    send_key(8'h1B);
    chk("lap_ss_state", bus.state, 2);
    chk("lap_ss_hold", bus.lap_hold, 0);

    // ---- reset mid-run from LAP ----
    send_key(8'h1B);
    send_key(8'h4B);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", bus.state, 0);
    chk("midrst_lap", bus.lap_hold, 0);
    chk("midrst_run", bus.running, 0);
    chk("midrst_tick", bus.tick_inc, 0);
    rst = 1'b0;

    // ---- typematic repeat / break / extended prefix ----
    do_reset();
    send_key(8'h1B);
    chk("rep1", bus.state, 1);
    send_key(8'h1B);
`ifdef SWC_REPEAT_FILTER_EN
    chk("rep2", bus.state, 1);
`else
    chk("rep2", bus.state, 2);
`endif
    send_key(8'h1B);
    chk("rep3", bus.state, 1);
    send_key(8'hF0);
    chk("rep_brk", bus.state, 1);
    send_key(8'h1B);
    chk("rep_release", bus.state, 1);
    send_key(8'h1B);
    chk("rep_new_press", bus.state, 2);
    send_key(8'hF0);
    send_key(8'hE0);
    send_key(8'h1B);
    chk("ext_release", bus.state, 2);
    send_key(8'h1C);
    chk("unknown_key", bus.state, 2);
    send_key(8'h1B);
    chk("after_ext", bus.state, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
